// File: rtl/dac_pkg.sv
//==============================================================================
// Module   : dac_pkg
// Purpose  : Shared constants and state encoding for the DAC frame scheduler.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package dac_pkg;

    localparam int         DATA_W   = 8;
    localparam int         FRAME_W  = 16;
    localparam logic [7:0] DAC_CTRL = 8'h00;
    localparam int         DIV_MIN  = 18;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } dac_state_t;

endpackage

`default_nettype wire

// File: rtl/dac_rr_arbiter.sv
//==============================================================================
// Module   : dac_rr_arbiter
// Purpose  : Two-source arbiter, round-robin or fixed priority to source 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dac_rr_arbiter (
    input  logic       clk_10M,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic       prio_mode,
    input  logic       accept,
    output logic       gnt
);

    logic r_last_grant;

    // On a tie, round-robin hands the slot to whichever source did not win last.
    always_comb begin
        gnt = 1'b0;
        if (req_valid == 2'b11) begin
            gnt = prio_mode ? 1'b0 : ~r_last_grant;
        end else if (req_valid[1]) begin
            gnt = 1'b1;
        end
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (accept) begin
            r_last_grant <= gnt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_frame_scheduler.sv
//==============================================================================
// Module   : dac_frame_scheduler
// Purpose  : Paces, arbitrates and serializes sample frames onto the DAC link.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dac_frame_scheduler #(
    parameter int DIV     = 100,
    parameter int DATA_W  = dac_pkg::DATA_W,
    parameter int FRAME_W = dac_pkg::FRAME_W
) (
    input  logic                clk_10M,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    input  logic                prio_mode,
    output logic                CS,
    output logic                DIN,
    output logic                grant,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          underrun_cnt
);

    import dac_pkg::*;

    localparam int                          c_tcnt_w   = $clog2(DIV);
    localparam int                          c_bcnt_w   = $clog2(FRAME_W);
    localparam logic [c_tcnt_w-1:0]         c_tick_last = c_tcnt_w'(DIV - 1);
    localparam logic [c_bcnt_w-1:0]         c_bit_last  = c_bcnt_w'(FRAME_W - 1);
    localparam logic [FRAME_W-DATA_W-1:0]   c_ctrl      = (FRAME_W - DATA_W)'(DAC_CTRL);

    generate
        if (DIV < DIV_MIN) begin : g_div_check
            $error("dac_frame_scheduler: DIV=%0d is below the minimum of %0d", DIV, DIV_MIN);
        end
    endgenerate

    dac_state_t            r_state, w_state_nxt;
    logic [c_tcnt_w-1:0]   r_tcnt;
    logic [FRAME_W-1:0]    r_sreg, w_sreg_nxt;
    logic [c_bcnt_w-1:0]   r_bcnt, w_bcnt_nxt;
    logic                  r_cs, w_cs_nxt;
    logic                  r_din, w_din_nxt;
    logic                  r_grant, w_grant_nxt;
    logic                  r_frame_done, w_done_nxt;
    logic [7:0]            r_underrun, w_underrun_nxt;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_gnt;
    logic [FRAME_W-1:0]    w_frame;

    assign w_tick  = (r_tcnt == c_tick_last);
    assign w_frame = {c_ctrl, (w_gnt ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0])};

    dac_rr_arbiter u_arbiter (
        .clk_10M   (clk_10M),
        .reset     (reset),
        .req_valid (req_valid),
        .prio_mode (prio_mode),
        .accept    (w_accept),
        .gnt       (w_gnt)
    );

    always_ff @(posedge clk_10M) begin
        if (reset || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // The first bit is loaded into DIN at the accept edge so CS and bit 15 appear together.
    always_comb begin
        w_state_nxt    = r_state;
        w_sreg_nxt     = r_sreg;
        w_bcnt_nxt     = r_bcnt;
        w_cs_nxt       = 1'b1;
        w_din_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        w_grant_nxt    = r_grant;
        w_underrun_nxt = r_underrun;
        w_accept       = 1'b0;
        req_ready      = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_tick && !reset) begin
                    if (|req_valid) begin
                        w_accept    = 1'b1;
                        req_ready   = w_gnt ? 2'b10 : 2'b01;
                        w_grant_nxt = w_gnt;
                        w_cs_nxt    = 1'b0;
                        w_din_nxt   = w_frame[FRAME_W-1];
                        w_sreg_nxt  = {w_frame[FRAME_W-2:0], 1'b0};
                        w_bcnt_nxt  = c_bit_last;
                        w_state_nxt = SHIFT;
                    end else if (r_underrun != 8'hFF) begin
                        w_underrun_nxt = r_underrun + 8'd1;
                    end
                end
            end
            SHIFT: begin
                if (r_bcnt == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cs_nxt   = 1'b0;
                    w_din_nxt  = r_sreg[FRAME_W-1];
                    w_sreg_nxt = {r_sreg[FRAME_W-2:0], 1'b0};
                    w_bcnt_nxt = r_bcnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sreg       <= '0;
            r_bcnt       <= '0;
            r_cs         <= 1'b1;
            r_din        <= 1'b0;
            r_grant      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_sreg       <= w_sreg_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_cs         <= w_cs_nxt;
            r_din        <= w_din_nxt;
            r_grant      <= w_grant_nxt;
            r_frame_done <= w_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign CS           = r_cs;
    assign DIN          = r_din;
    assign grant        = r_grant;
    assign busy         = (r_state == SHIFT);
    assign frame_done   = r_frame_done;
    assign underrun_cnt = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_dac_frame_scheduler.sv
//==============================================================================
// Module   : tb_dac_frame_scheduler
// Purpose  : Directed self-checking bench for dac_frame_scheduler (DIV=100).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dac_frame_scheduler;

    localparam int c_div = 100;

    logic        clk_10M = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        prio_mode;
    logic        CS;
    logic        DIN;
    logic        grant;
    logic        busy;
    logic        frame_done;
    logic [7:0]  underrun_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    logic ready1_seen;

    dac_frame_scheduler #(.DIV(c_div)) dut (
        .clk_10M      (clk_10M),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .prio_mode    (prio_mode),
        .CS           (CS),
        .DIN          (DIN),
        .grant        (grant),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun_cnt (underrun_cnt)
    );

    always #50 clk_10M = ~clk_10M;

    task automatic step();
        @(posedge clk_10M);
        #1;
        if (req_ready[1]) ready1_seen = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cs"}, CS, 1);
        chk({tag, "_din"}, DIN, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_underrun"}, underrun_cnt, 0);
    endtask

    // Counts edges until req_ready rises; CS must stay high and no frame_done may appear.
    task automatic wait_ready(input string tag, input int exp_edges);
        int   n       = 0;
        logic cs_low  = 1'b0;
        logic done_hi = 1'b0;
        while (req_ready == 2'b00 && n < 4 * c_div) begin
            step();
            n++;
            if (!CS) cs_low = 1'b1;
            if (frame_done) done_hi = 1'b1;
        end
        chk({tag, "_gap"}, n, exp_edges);
        chk({tag, "_cs_idle"}, cs_low, 0);
        chk({tag, "_no_done"}, done_hi, 0);
    endtask

    // Entered in the accept cycle; leaves one cycle after the frame_done pulse.
    task automatic do_frame(input string tag, input logic g, input logic [15:0] word);
        chk({tag, "_ready"}, req_ready, g ? 2'b10 : 2'b01);
        for (int k = 15; k >= 0; k--) begin
            step();
            chk({tag, "_cs_low"}, CS, 0);
            chk({tag, "_din"}, DIN, word[k]);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_done_early"}, frame_done, 0);
            if (k == 15) chk({tag, "_ready_once"}, req_ready, 0);
        end
        step();
        chk({tag, "_cs_end"}, CS, 1);
        chk({tag, "_din_end"}, DIN, 0);
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_grant"}, grant, g);
        step();
        chk({tag, "_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        logic cs_low;
        logic rdy_seen;

        reset       = 1'b1;
        req_valid   = 2'b00;
        req_data    = 16'h0000;
        prio_mode   = 1'b0;
        ready1_seen = 1'b0;

        // Reset state, then source 0 alone with 8'hFE.
        step(); step(); step();
        chk_reset_state("rst0");
        reset     = 1'b0;
        req_valid = 2'b01;
        req_data  = 16'h00FE;
        wait_ready("s0_first", c_div - 1);
        do_frame("s0_f1", 1'b0, 16'h00FE);
        wait_ready("s0_gap1", c_div - 18);
        do_frame("s0_f2", 1'b0, 16'h00FE);

        // Round-robin with both sources valid; last_grant resets to 1 so source 0 goes first.
        reset = 1'b1;
        step(); step();
        chk_reset_state("rst1");
        reset     = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'h0A7F;
        wait_ready("rr_first", c_div - 1);
        do_frame("rr_f1", 1'b0, 16'h007F);
        wait_ready("rr_gap1", c_div - 18);
        do_frame("rr_f2", 1'b1, 16'h000A);
        wait_ready("rr_gap2", c_div - 18);
        do_frame("rr_f3", 1'b0, 16'h007F);
        wait_ready("rr_gap3", c_div - 18);
        do_frame("rr_f4", 1'b1, 16'h000A);

        // Fixed priority: source 0 wins every tie.
        prio_mode   = 1'b1;
        ready1_seen = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_ready("fp_gap", c_div - 18);
            do_frame("fp_f", 1'b0, 16'h007F);
        end
        chk("fp_ready1_never", ready1_seen, 0);

        // 300 ticks with no valid source: underrun saturates at 255.
        prio_mode = 1'b0;
        req_valid = 2'b00;
        cs_low    = 1'b0;
        rdy_seen  = 1'b0;
        for (int i = 0; i < c_div - 17; i++) begin
            step();
            if (!CS) cs_low = 1'b1;
            if (req_ready != 2'b00) rdy_seen = 1'b1;
        end
        chk("ur_after_1", underrun_cnt, 1);
        for (int i = 0; i < c_div; i++) step();
        chk("ur_after_2", underrun_cnt, 2);
        for (int i = 0; i < 253 * c_div; i++) begin
            step();
            if (!CS) cs_low = 1'b1;
            if (req_ready != 2'b00) rdy_seen = 1'b1;
        end
        chk("ur_after_255", underrun_cnt, 255);
        for (int i = 0; i < 45 * c_div; i++) begin
            step();
            if (!CS) cs_low = 1'b1;
            if (req_ready != 2'b00) rdy_seen = 1'b1;
        end
        chk("ur_saturated", underrun_cnt, 255);
        chk("ur_cs_high", cs_low, 0);
        chk("ur_no_ready", rdy_seen, 0);

        // Source 1 becomes valid: next tick starts a frame, counter holds.
        req_valid = 2'b10;
        req_data  = 16'h0A00;
        wait_ready("ur_resume", c_div - 1);
        do_frame("ur_f", 1'b1, 16'h000A);
        chk("ur_hold", underrun_cnt, 255);

        // Reset during the 5th bit of a frame.
        wait_ready("mr_gap", c_div - 18);
        chk("mr_ready", req_ready, 2'b10);
        for (int i = 0; i < 5; i++) step();
        chk("mr_cs_5th", CS, 0);
        chk("mr_busy_5th", busy, 1);
        reset = 1'b1;
        step();
        chk("mr_cs", CS, 1);
        chk("mr_din", DIN, 0);
        chk("mr_done", frame_done, 0);
        chk("mr_busy", busy, 0);
        chk("mr_grant", grant, 0);
        chk("mr_underrun", underrun_cnt, 0);
        reset = 1'b0;
        wait_ready("mr_restart", c_div - 1);
        do_frame("mr_f", 1'b1, 16'h000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
